// File: rtl/seq_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_barrel_shifter
// Description : Multi-mode shift/rotate register with a start/busy/done
//               handshake. Performs 'amount' single-bit steps, one per clock
//               (LSL, LSR, ASR, ROR). The parallel-loaded word is held in Q.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;
  localparam logic [AMT_W-1:0] c_AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       mode_q,  mode_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] w_step;

  // Single-bit step of the held word, selected by the latched mode
  always_comb begin
    w_step = data_q;
    case (mode_q)
      M_LSL:   w_step = {data_q[WIDTH-2:0], 1'b0};
      M_LSR:   w_step = {1'b0, data_q[WIDTH-1:1]};
      M_ASR:   w_step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      M_ROR:   w_step = {data_q[0], data_q[WIDTH-1:1]};
      default: w_step = data_q;
    endcase
  end

  // State and datapath registers; async reset aborts any operation at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mode_q  <= M_LSL;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath update; load wins over start in IDLE
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!load_n) begin
          data_d = load_val;
        end else if (start) begin
          if (amount != c_AMT_ZERO) begin
            mode_d  = mode;
            count_d = amount;
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        data_d  = w_step;
        count_d = count_q - c_AMT_ONE;
        if (count_q == c_AMT_ONE) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
    Q    = data_q;
  end

endmodule
`default_nettype wire
